// File: rtl/nco_pwm_dac.sv
// 1-bit DAC stage behind the NCO: a one-entry sample buffer feeding either a
// PWM comparator or a first-order sigma-delta modulator, one frame per 2^DATA_W cycles.
module nco_pwm_dac #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] sampleIn,
   input  logic              sampleValid,
   output logic              sampleReady,
   input  logic [1:0]        modeIn,
   input  logic              clrUnderrun,
   output logic              dacOut,
   output logic              frameStart,
   output logic              underrun
);

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_PWM  = 2'b01,
      MODE_SD   = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   localparam logic [DATA_W-1:0] CNT_MAX = '1;
   localparam logic [DATA_W-1:0] CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] cnt;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] hold;
   logic [DATA_W-1:0] act;
   logic              hold_full;
   logic [1:0]        mode_prev;
   logic              dac_q;
   logic              frame_q;
   logic              underrun_q;

   mode_t             mode;
   logic              mode_chg;
   logic              run;
   logic              boundary;
   logic              accept;
   logic [DATA_W:0]   sum;

   assign mode        = mode_t'(modeIn);
   assign sampleReady = enable & ~hold_full;
   assign accept      = sampleValid & sampleReady;
   assign mode_chg    = enable && (modeIn != mode_prev);
   // a mode-change cycle only clears the datapath; it is never a live frame cycle
   assign run         = enable && !mode_chg && ((mode == MODE_PWM) || (mode == MODE_SD));
   assign boundary    = run && (cnt == CNT_MAX);
   assign sum         = {1'b0, acc} + {1'b0, act};

   assign dacOut     = dac_q;
   assign frameStart = frame_q;
   assign underrun   = underrun_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         acc     <= '0;
         dac_q   <= 1'b0;
         frame_q <= 1'b0;
      end else if (!enable) begin
         frame_q <= 1'b0;
      end else if (!run) begin
         cnt     <= '0;
         acc     <= '0;
         dac_q   <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         cnt     <= cnt + CNT_ONE;
         frame_q <= (cnt == '0);
         if (mode == MODE_PWM) begin
            dac_q <= (cnt < act);
         end else begin
            acc   <= sum[DATA_W-1:0];
            dac_q <= sum[DATA_W];
         end
      end
   end

   // accept and a loading boundary are exclusive: accept requires an empty hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= '0;
         hold_full <= 1'b0;
         act       <= '0;
      end else begin
         if (boundary && hold_full) begin
            act       <= hold;
            hold_full <= 1'b0;
         end
         if (accept) begin
            hold      <= sampleIn;
            hold_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_q <= 1'b0;
         mode_prev  <= 2'b00;
      end else if (enable) begin
         mode_prev <= modeIn;
         if (boundary && !hold_full) begin
            underrun_q <= 1'b1;
         end else if (clrUnderrun) begin
            underrun_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nco_pwm_dac.sv
// Bench for nco_pwm_dac: cycle-level reference model checked every clock, a table of
// per-frame duty vectors, hand-built corner sequences and a randomized run.
module tb_nco_pwm_dac;

   localparam int W = 8;
   localparam int N = 256;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic [W-1:0] sampleIn;
   logic         sampleValid;
   logic         sampleReady;
   logic [1:0]   modeIn;
   logic         clrUnderrun;
   logic         dacOut;
   logic         frameStart;
   logic         underrun;

   int checks = 0;
   int passes = 0;

   // reference model state
   int m_cnt, m_acc, m_hold, m_act, m_mprev;
   bit m_hfull, m_dac, m_fs, m_ur;

   nco_pwm_dac #(.DATA_W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .sampleIn    (sampleIn),
      .sampleValid (sampleValid),
      .sampleReady (sampleReady),
      .modeIn      (modeIn),
      .clrUnderrun (clrUnderrun),
      .dacOut      (dacOut),
      .frameStart  (frameStart),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic void check(string name, int actual, int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
   endfunction

   function automatic void model_reset();
      m_cnt = 0; m_acc = 0; m_hold = 0; m_act = 0; m_mprev = 0;
      m_hfull = 0; m_dac = 0; m_fs = 0; m_ur = 0;
   endfunction

   // advance the model by one clock using the inputs currently applied
   function automatic void model_step();
      int  mode;
      int  sum;
      bit  ready, chg, live, bnd;
      mode  = int'(modeIn);
      ready = enable && !m_hfull;
      chg   = enable && (mode != m_mprev);
      live  = enable && !chg && (mode == 1 || mode == 2);
      bnd   = live && (m_cnt == N - 1);
      if (!enable) begin
         m_fs = 0;
      end else if (!live) begin
         m_cnt = 0; m_acc = 0; m_dac = 0; m_fs = 0;
      end else begin
         m_fs = (m_cnt == 0);
         if (mode == 1) begin
            m_dac = (m_cnt < m_act);
         end else begin
            sum   = m_acc + m_act;
            m_dac = (sum >= N);
            m_acc = sum % N;
         end
         m_cnt = (m_cnt + 1) % N;
      end
      if (bnd && !m_hfull) m_ur = 1;
      else if (enable && clrUnderrun) m_ur = 0;
      if (bnd && m_hfull) begin
         m_act   = m_hold;
         m_hfull = 0;
      end
      if (sampleValid && ready) begin
         m_hold  = int'(sampleIn);
         m_hfull = 1;
      end
      if (enable) m_mprev = mode;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("dacOut", dacOut, m_dac);
      check("frameStart", frameStart, m_fs);
      check("underrun", underrun, m_ur);
      check("sampleReady", sampleReady, int'(enable && !m_hfull));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b1; sampleIn = '0; sampleValid = 1'b0; modeIn = 2'b00; clrUnderrun = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_dacOut", dacOut, 0);
      check("rst_frameStart", frameStart, 0);
      check("rst_underrun", underrun, 0);
      check("rst_sampleReady", sampleReady, 1);
   endtask

   task automatic wait_fs();
      bit seen;
      seen = 0;
      for (int i = 0; i < 700; i++) begin
         tick();
         if (frameStart) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check("fs_timeout", 0, 1);
   endtask

   // count dacOut highs over one frame, starting at the frameStart sample just observed
   task automatic count_frame(output int ones);
      ones = int'(dacOut);
      for (int i = 1; i < N; i++) begin
         tick();
         ones += int'(dacOut);
      end
   endtask

   typedef struct {
      logic [1:0]   mode;
      logic [W-1:0] val;
      int           exp_ones;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int ones;
      int len;
      bit d;
      bit seen;

      vecs[0] = '{2'b01, 8'h40, 64};
      vecs[1] = '{2'b01, 8'h00, 0};
      vecs[2] = '{2'b01, 8'hFF, 255};
      vecs[3] = '{2'b01, 8'h80, 128};
      vecs[4] = '{2'b10, 8'h80, 128};
      vecs[5] = '{2'b10, 8'h40, 64};

      // duty per frame, second frame after reset (first frame runs with act=0)
      for (int v = 0; v < 6; v++) begin
         do_reset();
         modeIn = vecs[v].mode;
         sampleIn = vecs[v].val;
         sampleValid = 1'b1;
         wait_fs();
         count_frame(ones);
         check("frame1_ones", ones, 0);
         wait_fs();
         count_frame(ones);
         check("frame2_ones", ones, vecs[v].exp_ones);
         tick();
         check("fs_period", frameStart, 1);
      end

      // underrun: one sample only
      do_reset();
      modeIn = 2'b01;
      sampleIn = 8'h55;
      sampleValid = 1'b1;
      tick();
      sampleValid = 1'b0;
      repeat (511) tick();
      check("underrun_pre", underrun, 0);
      tick();
      check("underrun_set", underrun, 1);
      wait_fs();
      count_frame(ones);
      check("act_kept_ones", ones, 'h55);
      clrUnderrun = 1'b1;
      tick();
      clrUnderrun = 1'b0;
      check("underrun_clr", underrun, 0);
      clrUnderrun = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (m_cnt == N - 1) break;
         tick();
      end
      tick();
      check("underrun_set_wins", underrun, 1);
      clrUnderrun = 1'b0;

      // enable drop stretches the frame, dacOut frozen
      do_reset();
      modeIn = 2'b01;
      sampleIn = 8'h80;
      sampleValid = 1'b1;
      wait_fs();
      wait_fs();
      len = 0;
      repeat (100) begin tick(); len++; end
      check("dac_high_mid", dacOut, 1);
      enable = 1'b0;
      d = dacOut;
      repeat (10) begin
         tick();
         len++;
         check("dac_frozen", dacOut, d);
      end
      enable = 1'b1;
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         len++;
         if (frameStart) begin
            seen = 1;
            break;
         end
      end
      check("stretch_seen", seen, 1);
      check("frame_len", len, 266);

      // PWM -> sigma-delta mid-frame
      repeat (50) tick();
      check("hold_full_before", sampleReady, 0);
      sampleValid = 1'b0;
      modeIn = 2'b10;
      tick();
      check("dac_after_switch", dacOut, 0);
      check("hold_after_switch", sampleReady, 0);
      tick();
      check("fs_after_switch", frameStart, 1);

      // async reset between edges
      modeIn = 2'b01;
      for (int i = 0; i < 1200; i++) begin
         if (m_ur) break;
         tick();
      end
      repeat (10) tick();
      check("ur_before_reset", underrun, 1);
      check("dac_before_reset", dacOut, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_dacOut", dacOut, 0);
      check("async_frameStart", frameStart, 0);
      check("async_underrun", underrun, 0);
      model_reset();
      modeIn = 2'b00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("ready_after_release", sampleReady, 1);
      @(posedge clk);
      #1;

      // randomized run against the model
      do_reset();
      modeIn = 2'b01;
      for (int i = 0; i < 3000; i++) begin
         enable      = ($urandom_range(0, 9) != 0);
         sampleValid = ($urandom_range(0, 3) == 0);
         sampleIn    = W'($urandom);
         clrUnderrun = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 199) == 0) modeIn = 2'($urandom_range(0, 3));
         tick();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
